// File: rtl/fracture_pkg.sv
// Shared types and helpers for the ring-phase fracture controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fracture_pkg;

    // FSM state codes, visible on stu_state
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_QUAL  = 3'd2,
        ST_FIRE  = 3'd3,
        ST_REARM = 3'd4
    } state_t;

    localparam int EVT_W = 16;
    localparam logic [EVT_W-1:0] EVT_SAT = {EVT_W{1'b1}};

    // Sticky status bundle kept together in the top
    typedef struct packed {
        logic             action;
        logic             timeout;
        logic [EVT_W-1:0] evt_cnt;
    } stu_t;

    // Re-arm level: threshold minus hysteresis, floored at zero
    function automatic logic [15:0] rearm_level(input logic [15:0] th,
                                                input logic [15:0] hyst);
        return (th > hyst) ? (th - hyst) : 16'd0;
    endfunction

endpackage

// File: rtl/fracture_wdog.sv
// Sample-arrival watchdog: counts idle cycles while running, pulses expire at the limit.
// Latency: expire is combinational from the registered count; count restarts the next edge.
// Backpressure: none; kick or !run zero the count, cfg_timeout==0 disables expiry.
module fracture_wdog
    import fracture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic             kick,
    input  logic             run,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;

    // A strobe arriving in the limit cycle counts as on time
    assign w_expire = run && !kick && (cfg_timeout != '0) && (r_cnt == cfg_timeout);
    assign expire   = w_expire;

    // Idle-cycle counter; restarts after each expiry
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!run || kick || w_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fracture_ctrl.sv
// Fracture sequencer: debounced threshold qualify -> timed act_out pulse -> hysteresis re-arm.
// Latency: act_out/status visible one edge after the final qualifying sample.
// Backpressure: none; samples outside ARMED/QUAL/REARM are ignored, cfg_en=0 forces IDLE.
module fracture_ctrl
    import fracture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic [15:0]      ph_ring,
    input  logic             ph_vld,
    input  logic             cfg_en,
    input  logic [15:0]      cfg_ring_th,
    input  logic [15:0]      cfg_hyst,
    input  logic [7:0]       cfg_debounce,
    input  logic [CNT_W-1:0] cfg_hold,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic             clr_action,
    input  logic             clr_cnt,
    output logic             act_out,
    output logic             stu_action,
    output logic             stu_timeout,
    output logic [EVT_W-1:0] stu_evt_cnt,
    output logic [2:0]       stu_state
);

    localparam logic [CNT_W-1:0] HOLD_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_qcnt;
    logic [CNT_W-1:0] r_hold;
    logic             r_act;
    stu_t             r_stu;

    logic [7:0]       w_deb_eff;
    logic [CNT_W-1:0] w_hold_eff;
    logic             w_qual;
    logic             w_low;
    logic             w_deb_hit;
    logic             w_run;
    logic             w_expire;
    logic             w_fire_entry;
    logic             w_act_nxt;

    assign w_deb_eff  = (cfg_debounce == 8'd0) ? 8'd1 : cfg_debounce;
    assign w_hold_eff = (cfg_hold == '0) ? HOLD_ONE : cfg_hold;
    assign w_qual     = ph_vld && (ph_ring >= cfg_ring_th);
    assign w_low      = ph_vld && (ph_ring < rearm_level(cfg_ring_th, cfg_hyst));
    // This sample would be the one that completes the debounce run
    assign w_deb_hit  = ({1'b0, r_qcnt} + 9'd1) >= {1'b0, w_deb_eff};
    assign w_run      = cfg_en && (r_state inside {ST_ARMED, ST_QUAL, ST_REARM});

    fracture_wdog #(.CNT_W(CNT_W)) u_wdog (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .cfg_timeout (cfg_timeout),
        .kick        (ph_vld),
        .run         (w_run),
        .expire      (w_expire)
    );

    // State register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; disable overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (!cfg_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (w_expire)    w_state_nxt = ST_ARMED;
                    else if (w_qual) w_state_nxt = (w_deb_eff == 8'd1) ? ST_FIRE : ST_QUAL;
                end
                ST_QUAL: begin
                    if (w_expire)     w_state_nxt = ST_ARMED;
                    else if (ph_vld)  w_state_nxt = !w_qual  ? ST_ARMED :
                                                    w_deb_hit ? ST_FIRE  : ST_QUAL;
                end
                ST_FIRE: begin
                    if (r_hold <= HOLD_ONE) w_state_nxt = ST_REARM;
                end
                ST_REARM: begin
                    if (w_expire || w_low) w_state_nxt = ST_ARMED;
                end
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode from the transition about to be taken
    always_comb begin
        w_fire_entry = (w_state_nxt == ST_FIRE) && (r_state != ST_FIRE);
        w_act_nxt    = (w_state_nxt == ST_FIRE);
    end

    // Registered action pulse
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_act <= 1'b0;
        else        r_act <= w_act_nxt;
    end

    // Hold counter: loaded on FIRE entry, counts down while FIRE persists
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_fire_entry) begin
            r_hold <= w_hold_eff;
        end else if ((r_state == ST_FIRE) && (w_state_nxt == ST_FIRE)) begin
            r_hold <= r_hold - 1'b1;
        end else begin
            r_hold <= '0;
        end
    end

    // Qualification count: only meaningful while staying in QUAL
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_qcnt <= 8'd0;
        end else if (w_state_nxt == ST_QUAL) begin
            r_qcnt <= (r_state == ST_QUAL) ? (r_qcnt + {7'd0, ph_vld}) : 8'd1;
        end else begin
            r_qcnt <= 8'd0;
        end
    end

    // Sticky status; a set/increment in the same cycle as a clear wins
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_stu <= '0;
        end else begin
            if (w_fire_entry)    r_stu.action <= 1'b1;
            else if (clr_action) r_stu.action <= 1'b0;

            if (w_expire)        r_stu.timeout <= 1'b1;
            else if (clr_action) r_stu.timeout <= 1'b0;

            if (w_fire_entry) begin
                if (r_stu.evt_cnt != EVT_SAT) r_stu.evt_cnt <= r_stu.evt_cnt + 1'b1;
            end else if (clr_cnt) begin
                r_stu.evt_cnt <= '0;
            end
        end
    end

    assign act_out     = r_act;
    assign stu_action  = r_stu.action;
    assign stu_timeout = r_stu.timeout;
    assign stu_evt_cnt = r_stu.evt_cnt;
    assign stu_state   = r_state;

endmodule
